// File: rtl/pc_stack_unit_if.sv
// Sequencer-side bus of pc_stack_unit: command/data inputs and PC/stack status outputs.
interface pc_stack_unit_if #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned LVL_W = 3
);
    logic              DONE;
    logic [2:0]        HAB;
    logic [PC_W-1:0]   RX_DATO;
    logic              ERR_CLR;
    logic [PC_W-1:0]   PC_VAL;
    logic [LVL_W-1:0]  STK_LVL;
    logic              STK_FULL;
    logic              STK_EMPTY;
    logic              STK_ERR;

    modport master (
        output DONE, HAB, RX_DATO, ERR_CLR,
        input  PC_VAL, STK_LVL, STK_FULL, STK_EMPTY, STK_ERR
    );

    modport slave (
        input  DONE, HAB, RX_DATO, ERR_CLR,
        output PC_VAL, STK_LVL, STK_FULL, STK_EMPTY, STK_ERR
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with load, relative branch, hold and optional call/return stack.
// Define PC_STACK_EN to build the return-address stack; otherwise call acts as a load.
module pc_stack_unit #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned LVL_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    pc_stack_unit_if.slave     bus
);
    localparam logic [2:0] CMD_HOLD  = 3'b001;
    localparam logic [2:0] CMD_LD0   = 3'b010;
    localparam logic [2:0] CMD_LD1   = 3'b011;
    localparam logic [2:0] CMD_CALL  = 3'b100;
    localparam logic [2:0] CMD_RET   = 3'b101;
    localparam logic [2:0] CMD_REL   = 3'b110;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc     = pc_q + PC_W'(1);
    assign bus.PC_VAL = pc_q;

`ifdef PC_STACK_EN
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0]  stk_q [STACK_DEPTH];
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic             err_set;
    logic             push;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;

    // push_idx is only used when not full, so truncation never aliases
    assign push_idx = IDX_W'(lvl_q);
    assign top_idx  = IDX_W'(lvl_q - LVL_W'(1));

    // Command decode; a command in 001..110 masks DONE
    always_comb begin
        pc_d    = pc_q;
        lvl_d   = lvl_q;
        err_set = 1'b0;
        push    = 1'b0;
        case (bus.HAB)
            CMD_HOLD: ;
            CMD_LD0, CMD_LD1: pc_d = bus.RX_DATO;
            CMD_CALL: begin
                if (!full_q) begin
                    push  = 1'b1;
                    pc_d  = bus.RX_DATO;
                    lvl_d = lvl_q + LVL_W'(1);
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_RET: begin
                if (!empty_q) begin
                    pc_d  = stk_q[top_idx];
                    lvl_d = lvl_q - LVL_W'(1);
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_REL: pc_d = pc_q + bus.RX_DATO;
            default: if (bus.DONE) pc_d = pc_inc;
        endcase
        err_d   = err_set | (err_q & ~bus.ERR_CLR);
        full_d  = (lvl_d == LVL_W'(STACK_DEPTH));
        empty_d = (lvl_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            lvl_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            lvl_q   <= lvl_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stk_q[push_idx] <= pc_inc;
        end
    end

    assign bus.STK_LVL   = lvl_q;
    assign bus.STK_FULL  = full_q;
    assign bus.STK_EMPTY = empty_q;
    assign bus.STK_ERR   = err_q;
`else
    logic unused_cfg;

    // Call degenerates to an absolute load, return to a no-op
    always_comb begin
        pc_d = pc_q;
        case (bus.HAB)
            CMD_HOLD, CMD_RET: ;
            CMD_LD0, CMD_LD1, CMD_CALL: pc_d = bus.RX_DATO;
            CMD_REL: pc_d = pc_q + bus.RX_DATO;
            default: if (bus.DONE) pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign unused_cfg    = ^{bus.ERR_CLR, LVL_W'(STACK_DEPTH)};
    assign bus.STK_LVL   = LVL_W'(0);
    assign bus.STK_FULL  = 1'b0;
    assign bus.STK_EMPTY = 1'b1;
    assign bus.STK_ERR   = 1'b0;
`endif
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit; stack checks are selected by PC_STACK_EN.
module tb_pc_stack_unit;
    localparam int unsigned PC_W        = 8;
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned LVL_W       = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    pc_stack_unit_if #(.PC_W(PC_W), .LVL_W(LVL_W)) bus ();

    pc_stack_unit #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH), .LVL_W(LVL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic d, input logic [2:0] h, input logic [7:0] r, input logic c);
        bus.DONE    = d;
        bus.HAB     = h;
        bus.RX_DATO = r;
        bus.ERR_CLR = c;
        @(posedge clk);
        #1;
        bus.DONE    = 1'b0;
        bus.HAB     = 3'b000;
        bus.ERR_CLR = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stk(input string tag, input logic [7:0] pc, input int lvl,
                           input logic full, input logic empty, input logic err);
        chk({tag, ".pc"},    32'(bus.PC_VAL),    32'(pc));
        chk({tag, ".lvl"},   32'(bus.STK_LVL),   32'(lvl));
        chk({tag, ".full"},  32'(bus.STK_FULL),  32'(full));
        chk({tag, ".empty"}, 32'(bus.STK_EMPTY), 32'(empty));
        chk({tag, ".err"},   32'(bus.STK_ERR),   32'(err));
    endtask

    initial begin
        bus.DONE = 1'b0; bus.HAB = 3'b000; bus.RX_DATO = '0; bus.ERR_CLR = 1'b0;
        reset = 1'b1;
        cyc(1'b1, 3'b010, 8'h55, 1'b0);
        cyc(1'b0, 3'b000, 8'h00, 1'b0);
        reset = 1'b0;
        chk_stk("reset", 8'h00, 0, 1'b0, 1'b1, 1'b0);

        // Free-running increment with wrap
        for (int i = 0; i < 255; i++) cyc(1'b1, 3'b000, 8'h00, 1'b0);
        chk("inc_255", 32'(bus.PC_VAL), 32'hFF);
        cyc(1'b1, 3'b000, 8'h00, 1'b0);
        chk("inc_wrap", 32'(bus.PC_VAL), 32'h00);
        for (int i = 0; i < 44; i++) cyc(1'b1, 3'b000, 8'h00, 1'b0);
        chk("inc_300", 32'(bus.PC_VAL), 32'd44);

        cyc(1'b0, 3'b000, 8'h77, 1'b0);
        chk("idle", 32'(bus.PC_VAL), 32'd44);
        cyc(1'b1, 3'b111, 8'h77, 1'b0);
        chk("hab111_done", 32'(bus.PC_VAL), 32'd45);
        cyc(1'b1, 3'b001, 8'h77, 1'b0);
        chk("hold_done", 32'(bus.PC_VAL), 32'd45);

        cyc(1'b0, 3'b011, 8'h10, 1'b0);
        chk("load_011", 32'(bus.PC_VAL), 32'h10);
        cyc(1'b1, 3'b010, 8'h80, 1'b0);
        chk("load_with_done", 32'(bus.PC_VAL), 32'h80);

        cyc(1'b0, 3'b010, 8'h02, 1'b0);
        cyc(1'b1, 3'b110, 8'hFC, 1'b0);
        chk("rel_neg", 32'(bus.PC_VAL), 32'hFE);
        cyc(1'b0, 3'b110, 8'h03, 1'b0);
        chk("rel_pos_wrap", 32'(bus.PC_VAL), 32'h01);
        cyc(1'b0, 3'b110, 8'h7F, 1'b0);
        chk("rel_max", 32'(bus.PC_VAL), 32'h80);

`ifdef PC_STACK_EN
        cyc(1'b0, 3'b010, 8'h05, 1'b0);
        cyc(1'b1, 3'b100, 8'h40, 1'b0);
        chk_stk("call1", 8'h40, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'b000, 8'h00, 1'b0);
        chk("call1_done3", 32'(bus.PC_VAL), 32'h43);
        cyc(1'b1, 3'b101, 8'h00, 1'b0);
        chk_stk("ret1", 8'h06, 0, 1'b0, 1'b1, 1'b0);

        // Fill to depth 4, then overflow
        cyc(1'b0, 3'b100, 8'h10, 1'b0);
        cyc(1'b0, 3'b100, 8'h20, 1'b0);
        cyc(1'b0, 3'b100, 8'h30, 1'b0);
        chk_stk("call3", 8'h30, 3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 3'b100, 8'h50, 1'b0);
        chk_stk("call4_full", 8'h50, 4, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'b100, 8'h60, 1'b0);
        chk_stk("call5_ovf", 8'h50, 4, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        chk_stk("ret_a", 8'h31, 3, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        chk("ret_b", 32'(bus.PC_VAL), 32'h21);
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        chk("ret_c", 32'(bus.PC_VAL), 32'h11);
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        chk_stk("ret_d", 8'h07, 0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 3'b101, 8'h00, 1'b0);
        chk_stk("ret5_udf", 8'h07, 0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 3'b000, 8'h00, 1'b1);
        chk("err_clr", 32'(bus.STK_ERR), 32'h0);
        cyc(1'b0, 3'b101, 8'h00, 1'b1);
        chk("err_set_wins", 32'(bus.STK_ERR), 32'h1);
        cyc(1'b0, 3'b000, 8'h00, 1'b1);
        chk("err_clr2", 32'(bus.STK_ERR), 32'h0);

        // Back-to-back call then return, pushed value at wrap edge
        cyc(1'b0, 3'b010, 8'hFF, 1'b0);
        cyc(1'b0, 3'b100, 8'h40, 1'b0);
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        chk_stk("b2b_wrap", 8'h00, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 3'b010, 8'h07, 1'b0);
        cyc(1'b0, 3'b100, 8'h40, 1'b0);
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        chk("b2b", 32'(bus.PC_VAL), 32'h08);

        // Reset during a call after an underflow
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        cyc(1'b0, 3'b100, 8'h20, 1'b0);
        cyc(1'b0, 3'b100, 8'h30, 1'b0);
        chk_stk("pre_reset", 8'h30, 2, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        cyc(1'b1, 3'b100, 8'h60, 1'b0);
        reset = 1'b0;
        chk_stk("mid_reset", 8'h00, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 3'b100, 8'h44, 1'b0);
        cyc(1'b0, 3'b101, 8'h00, 1'b0);
        chk_stk("post_reset", 8'h01, 0, 1'b0, 1'b1, 1'b0);
`else
        cyc(1'b0, 3'b010, 8'h05, 1'b0);
        cyc(1'b1, 3'b100, 8'h40, 1'b0);
        chk_stk("nostk_call", 8'h40, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 3'b101, 8'h00, 1'b0);
        chk_stk("nostk_ret", 8'h40, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 3'b101, 8'h00, 1'b1);
        chk_stk("nostk_ret2", 8'h40, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 3'b000, 8'h00, 1'b0);
        chk("nostk_inc", 32'(bus.PC_VAL), 32'h41);
        reset = 1'b1;
        cyc(1'b1, 3'b010, 8'h60, 1'b0);
        reset = 1'b0;
        chk_stk("mid_reset", 8'h00, 0, 1'b0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
